// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, mid-bit sampling, false-start rejection,
// optional parity and 1..2 stop bits; one-cycle valid strobe with error flags.
module uart_rx #(
   parameter int    WORD_LENGTH = 8,
   parameter string PARITY      = "none",
   parameter int    STOP_BITS   = 1,
   parameter int    BAUD_RATE   = 9600,
   parameter int    CLK_FREQ    = 50_000_000,
   parameter int    OVERSAMPLE  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx_in,
   output logic [WORD_LENGTH-1:0] rx_data,
   output logic                   rx_valid,
   output logic                   parity_err,
   output logic                   frame_err,
   output logic                   rx_busy,
   output logic [2:0]             o_dbg_state
);

   localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int SW       = $clog2(OVERSAMPLE);
   localparam int BW       = $clog2(WORD_LENGTH);

   localparam logic [31:0]   TICK_LAST = 32'(TICK_DIV - 1);
   localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] BIT_LAST  = SW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] WORD_LAST = BW'(WORD_LENGTH - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic          PAR_EN    = (PARITY != "none");
   localparam logic          PAR_ODD   = (PARITY == "odd");

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      PARITY_S = 3'd3,
      STOP     = 3'd4,
      BREAK    = 3'd5
   } state_t;

   state_t                 r_state;
   logic [1:0]             r_sync;
   logic [31:0]            r_tick_cnt;
   logic [SW-1:0]          r_sample_cnt;
   logic [BW-1:0]          r_bit_cnt;
   logic                   r_stop_cnt;
   logic [WORD_LENGTH-1:0] r_shift;
   logic                   r_perr_pend;
   logic                   r_ferr_pend;
   logic [WORD_LENGTH-1:0] r_data;
   logic                   r_valid;
   logic                   r_perr;
   logic                   r_ferr;
   logic                   r_busy;

   logic w_rx_s;
   logic w_tick;
   logic w_ferr_next;

   assign w_rx_s      = r_sync[1];
   assign w_tick      = (r_tick_cnt == TICK_LAST);
   assign w_ferr_next = r_ferr_pend | ~w_rx_s;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync     <= 2'b11;
         r_tick_cnt <= '0;
      end else begin
         r_sync     <= {r_sync[0], rx_in};
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 32'd1;
      end
   end

   // All frame actions happen on ticks; only the valid strobe clears every clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_sample_cnt <= '0;
         r_bit_cnt    <= '0;
         r_stop_cnt   <= 1'b0;
         r_shift      <= '0;
         r_perr_pend  <= 1'b0;
         r_ferr_pend  <= 1'b0;
         r_data       <= '0;
         r_valid      <= 1'b0;
         r_perr       <= 1'b0;
         r_ferr       <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_tick) begin
            case (r_state)
               IDLE: begin
                  r_busy <= 1'b0;
                  if (!w_rx_s) begin
                     r_state      <= START;
                     r_sample_cnt <= '0;
                  end
               end
               START: begin
                  if (r_sample_cnt == HALF_LAST) begin
                     if (w_rx_s) begin
                        r_state <= IDLE;
                     end else begin
                        r_state      <= DATA;
                        r_sample_cnt <= '0;
                        r_bit_cnt    <= '0;
                        r_perr_pend  <= 1'b0;
                        r_ferr_pend  <= 1'b0;
                        r_busy       <= 1'b1;
                     end
                  end else begin
                     r_sample_cnt <= r_sample_cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (r_sample_cnt == BIT_LAST) begin
                     r_sample_cnt <= '0;
                     r_shift      <= {w_rx_s, r_shift[WORD_LENGTH-1:1]};
                     if (r_bit_cnt == WORD_LAST) begin
                        r_state    <= PAR_EN ? PARITY_S : STOP;
                        r_stop_cnt <= 1'b0;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end else begin
                     r_sample_cnt <= r_sample_cnt + 1'b1;
                  end
               end
               PARITY_S: begin
                  if (r_sample_cnt == BIT_LAST) begin
                     r_sample_cnt <= '0;
                     r_perr_pend  <= (^r_shift) ^ w_rx_s ^ PAR_ODD;
                     r_state      <= STOP;
                     r_stop_cnt   <= 1'b0;
                  end else begin
                     r_sample_cnt <= r_sample_cnt + 1'b1;
                  end
               end
               STOP: begin
                  if (r_sample_cnt == BIT_LAST) begin
                     r_sample_cnt <= '0;
                     r_ferr_pend  <= w_ferr_next;
                     if (r_stop_cnt == STOP_LAST) begin
                        // Leave at mid-stop so a back-to-back start edge is not missed.
                        r_data  <= r_shift;
                        r_perr  <= r_perr_pend;
                        r_ferr  <= w_ferr_next;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= w_ferr_next ? BREAK : IDLE;
                     end else begin
                        r_stop_cnt <= 1'b1;
                     end
                  end else begin
                     r_sample_cnt <= r_sample_cnt + 1'b1;
                  end
               end
               BREAK: begin
                  if (w_rx_s) r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign rx_data     = r_data;
   assign rx_valid    = r_valid;
   assign parity_err  = r_perr;
   assign frame_err   = r_ferr;
   assign rx_busy     = r_busy;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one receiver without parity (a) and one with even
// parity (b); TICK_DIV = 10, so one bit lasts 160 clk.
module tb_uart_rx;

   localparam int BIT_CLK = 160;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_BREAK = 3'd5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid, a_perr, b_perr, a_ferr, b_ferr, a_busy, b_busy;
   logic [2:0] a_state, b_state;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;
   int t_fall = 0;
   int a_last_cyc = 0;
   int b_last_cyc = 0;

   logic [9:0] a_got[$];
   logic [9:0] b_got[$];
   logic [9:0] exp_q[$];

   typedef struct {
      int         sel;
      logic [7:0] data;
      int         par;
      logic       stop_v;
      logic [9:0] exp;
      int         lat;
   } vec_t;

   uart_rx #(.WORD_LENGTH(8), .PARITY("none"), .STOP_BITS(1), .BAUD_RATE(10_000),
             .CLK_FREQ(1_600_000), .OVERSAMPLE(16)) u_dut_a (
      .clk(clk), .reset(reset), .rx_in(rx_a), .rx_data(a_data), .rx_valid(a_valid),
      .parity_err(a_perr), .frame_err(a_ferr), .rx_busy(a_busy), .o_dbg_state(a_state));

   uart_rx #(.WORD_LENGTH(8), .PARITY("even"), .STOP_BITS(1), .BAUD_RATE(10_000),
             .CLK_FREQ(1_600_000), .OVERSAMPLE(16)) u_dut_b (
      .clk(clk), .reset(reset), .rx_in(rx_b), .rx_data(b_data), .rx_valid(b_valid),
      .parity_err(b_perr), .frame_err(b_ferr), .rx_busy(b_busy), .o_dbg_state(b_state));

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // strobe monitor: every valid cycle is recorded as {parity_err, frame_err, data}
   always @(negedge clk) begin
      if (a_valid) begin
         a_got.push_back({a_perr, a_ferr, a_data});
         a_last_cyc = cyc;
      end
      if (b_valid) begin
         b_got.push_back({b_perr, b_ferr, b_data});
         b_last_cyc = cyc;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic set_line(input int sel, input logic v);
      if (sel == 0) rx_a = v;
      else rx_b = v;
   endtask

   task automatic hold_bit(input int sel, input logic v);
      set_line(sel, v);
      repeat (BIT_CLK) @(posedge clk);
      #1;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input int par, input logic stop_v);
      t_fall = cyc;
      hold_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
      if (par >= 0) hold_bit(sel, par[0]);
      hold_bit(sel, stop_v);
   endtask

   // scoreboard: compare received strobes of one receiver against exp_q
   task automatic check_strobes(input int sel, input string name);
      logic [9:0] got;
      logic [9:0] exp;
      check({name, " strobe count"}, (sel == 0) ? a_got.size() : b_got.size(), exp_q.size());
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         if (sel == 0 && a_got.size() > 0) begin
            got = a_got.pop_front();
            check({name, " word"}, got, exp);
         end else if (sel != 0 && b_got.size() > 0) begin
            got = b_got.pop_front();
            check({name, " word"}, got, exp);
         end
      end
      a_got.delete();
      b_got.delete();
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, " a rx_data"}, a_data, 0);
      check({name, " a rx_valid"}, a_valid, 0);
      check({name, " a parity_err"}, a_perr, 0);
      check({name, " a frame_err"}, a_ferr, 0);
      check({name, " a rx_busy"}, a_busy, 0);
      check({name, " a state"}, a_state, ST_IDLE);
      check({name, " b rx_data"}, b_data, 0);
      check({name, " b rx_busy"}, b_busy, 0);
   endtask

   vec_t vecs[6];

   initial begin
      int lat;
      // {sel, data, parity bit (-1 none), stop level, expected {perr,ferr,data}, latency}
      vecs[0] = '{0, 8'hA5, -1, 1'b1, {2'b00, 8'hA5}, 1520};
      vecs[1] = '{1, 8'h3C,  0, 1'b1, {2'b00, 8'h3C}, 1680};
      vecs[2] = '{1, 8'h3C,  1, 1'b1, {2'b10, 8'h3C}, 1680};
      vecs[3] = '{0, 8'h00, -1, 1'b1, {2'b00, 8'h00}, 1520};
      vecs[4] = '{1, 8'h07,  1, 1'b1, {2'b00, 8'h07}, 1680};
      vecs[5] = '{1, 8'h07,  0, 1'b1, {2'b10, 8'h07}, 1680};

      // reset
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1 reset = 1'b0;
      wait_clk(50);

      // single frames from the table
      for (int v = 0; v < 6; v++) begin
         send_frame(vecs[v].sel, vecs[v].data, vecs[v].par, vecs[v].stop_v);
         lat = ((vecs[v].sel == 0) ? a_last_cyc : b_last_cyc) - t_fall;
         n_checks++;
         if (lat < vecs[v].lat - 10 || lat > vecs[v].lat + 10) begin
            n_fail++;
            $display("FAIL vec%0d latency: got %0d clk expected %0d +/-10", v, lat, vecs[v].lat);
         end
         wait_clk(200);
         exp_q.push_back(vecs[v].exp);
         check_strobes(vecs[v].sel, $sformatf("vec%0d", v));
      end

      // 40-clk low glitch is rejected as a false start
      set_line(0, 1'b0);
      wait_clk(40);
      set_line(0, 1'b1);
      wait_clk(300);
      check_strobes(0, "glitch");
      check("glitch busy", a_busy, 0);
      check("glitch state", a_state, ST_IDLE);

      // frame error followed by a held-low line, then a clean frame
      send_frame(0, 8'h55, -1, 1'b0);
      wait_clk(1500);
      check("break state", a_state, ST_BREAK);
      check("break strobes so far", a_got.size(), 1);
      wait_clk(1500);
      set_line(0, 1'b1);
      wait_clk(200);
      send_frame(0, 8'h0F, -1, 1'b1);
      wait_clk(200);
      exp_q.push_back({2'b01, 8'h55});
      exp_q.push_back({2'b00, 8'h0F});
      check_strobes(0, "break");
      check("break exit state", a_state, ST_IDLE);

      // back-to-back frames with no idle gap
      send_frame(0, 8'h01, -1, 1'b1);
      send_frame(0, 8'hFF, -1, 1'b1);
      send_frame(0, 8'h80, -1, 1'b1);
      wait_clk(300);
      exp_q.push_back({2'b00, 8'h01});
      exp_q.push_back({2'b00, 8'hFF});
      exp_q.push_back({2'b00, 8'h80});
      check_strobes(0, "b2b");

      // reset in the middle of data bit 4, then a clean frame
      hold_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) hold_bit(0, 1'b1);
      set_line(0, 1'b1);
      wait_clk(80);
      check("midframe busy", a_busy, 1);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_reset_outputs($sformatf("midreset%0d", i));
      end
      @(posedge clk);
      #1 reset = 1'b0;
      wait_clk(400);
      send_frame(0, 8'h5A, -1, 1'b1);
      wait_clk(200);
      exp_q.push_back({2'b00, 8'h5A});
      check_strobes(0, "after reset");
      check("after reset busy", a_busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
